// File: rtl/multiplicador_4b_pkg.sv
// Shared constants for the push-button arithmetic blocks (multiplier and divider).
package multiplicador_4b_pkg;

  localparam int WIDTH_DEF = 4;

  // Button lines idle high; a press pulls the line low.
  localparam logic BTN_PRESSED = 1'b0;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    CALC    = 3'd2,
    SHOW_HI = 3'd3,
    SHOW_LO = 3'd4
  } state_t;

endpackage

// File: rtl/multiplicador_4b_if.sv
// Board UI bundle: three active-low buttons in, WIDTH LEDs out.
interface multiplicador_4b_if
  import multiplicador_4b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             down;
  logic             up;
  logic             ok;
  logic [WIDTH-1:0] leds;

  modport master (output down, output up, output ok, input leds);
  modport slave  (input down, input up, input ok, output leds);
endinterface

// File: rtl/multiplicador_4b_boton_pulso.sv
// Button conditioner: synchronizer chain plus falling-edge detector that
// emits one clk-wide pulse per press.
module boton_pulso
  import multiplicador_4b_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FILL_DONE = CW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CW-1:0]          fill_q;

  // The chain resets to "released", which is not a real sample of the pin.
  // Until the chain has been refilled with real samples, prev is held at
  // "pressed" so a button held across reset release cannot look like a
  // fresh falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= BTN_PRESSED;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      if (fill_q != FILL_DONE) begin
        fill_q <= fill_q + 1'b1;
      end
      prev_q <= (fill_q == FILL_DONE) ? sync_q[SYNC_STAGES-1] : BTN_PRESSED;
    end
  end

  assign pulse = (prev_q != BTN_PRESSED) && (sync_q[SYNC_STAGES-1] == BTN_PRESSED);

endmodule

// File: rtl/multiplicador_4b.sv
// Push-button multiplier: enter A and B with up/down/ok, shift-add engine
// computes A*B in WIDTH cycles, product shown high nibble then low nibble.
module multiplicador_4b
  import multiplicador_4b_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  multiplicador_4b_if.slave  bus
);

  localparam int PW   = 2 * WIDTH;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

  logic up_p;
  logic down_p;
  logic ok_p;

  state_t           state_q;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mult_q;
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    prod_q;
  logic [CNTW-1:0]  iter_q;
  logic [WIDTH-1:0] leds_q;
  logic [PW-1:0]    acc_nxt;
  logic [WIDTH-1:0] entry_nxt;

  // Entry counter step; simultaneous up and down cancel out.
  function automatic logic [WIDTH-1:0] step_entry(input logic [WIDTH-1:0] v,
                                                  input logic inc,
                                                  input logic dec);
    if (inc && !dec) begin
      return v + 1'b1;
    end else if (dec && !inc) begin
      return v - 1'b1;
    end
    return v;
  endfunction

  // One shift-add iteration: accumulate the shifted multiplicand when the
  // current multiplier bit is set.
  function automatic logic [PW-1:0] mac_step(input logic [PW-1:0] acc,
                                             input logic [PW-1:0] mcand,
                                             input logic          lsb);
    return lsb ? acc + mcand : acc;
  endfunction

  boton_pulso #(.SYNC_STAGES(SYNC_STAGES)) u_btn_up (
    .clk(clk), .rst(rst), .btn(bus.up), .pulse(up_p)
  );

  boton_pulso #(.SYNC_STAGES(SYNC_STAGES)) u_btn_down (
    .clk(clk), .rst(rst), .btn(bus.down), .pulse(down_p)
  );

  boton_pulso #(.SYNC_STAGES(SYNC_STAGES)) u_btn_ok (
    .clk(clk), .rst(rst), .btn(bus.ok), .pulse(ok_p)
  );

  assign acc_nxt   = mac_step(acc_q, mcand_q, mult_q[0]);
  assign entry_nxt = step_entry(value_q, up_p, down_p);

  // Control FSM, operand/product registers and registered LED output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD_A;
      value_q <= '0;
      a_q     <= '0;
      mult_q  <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      iter_q  <= '0;
      leds_q  <= '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (ok_p) begin
            a_q     <= value_q;
            value_q <= '0;
            leds_q  <= '0;
            state_q <= LOAD_B;
          end else begin
            value_q <= entry_nxt;
            leds_q  <= entry_nxt;
          end
        end
        LOAD_B: begin
          if (ok_p) begin
            mult_q  <= value_q;
            mcand_q <= {{WIDTH{1'b0}}, a_q};
            acc_q   <= '0;
            iter_q  <= '0;
            state_q <= CALC;
          end else begin
            value_q <= entry_nxt;
            leds_q  <= entry_nxt;
          end
        end
        CALC: begin
          acc_q   <= acc_nxt;
          mcand_q <= mcand_q << 1;
          mult_q  <= mult_q >> 1;
          iter_q  <= iter_q + 1'b1;
          if (iter_q == LAST_ITER) begin
            prod_q  <= acc_nxt;
            leds_q  <= acc_nxt[PW-1:WIDTH];
            state_q <= SHOW_HI;
          end
        end
        SHOW_HI: begin
          if (ok_p) begin
            leds_q  <= prod_q[WIDTH-1:0];
            state_q <= SHOW_LO;
          end
        end
        SHOW_LO: begin
          if (ok_p) begin
            value_q <= '0;
            leds_q  <= '0;
            state_q <= LOAD_A;
          end
        end
        default: begin
          value_q <= '0;
          leds_q  <= '0;
          state_q <= LOAD_A;
        end
      endcase
    end
  end

  assign bus.leds = leds_q;

endmodule

// File: tb/tb_multiplicador_4b.sv
// Scoreboard bench for the push-button multiplier.
module tb_multiplicador_4b;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  multiplicador_4b_if #(.WIDTH(WIDTH)) bus ();

  multiplicador_4b #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  string            tag_q[$];

  task automatic check_val(input string tag, input logic [WIDTH-1:0] act,
                           input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: leds=0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [WIDTH-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Compare the oldest outstanding expectation against the LEDs now.
  task automatic score();
    logic [WIDTH-1:0] v;
    string            t;
    v = exp_q.pop_front();
    t = tag_q.pop_front();
    check_val(t, bus.leds, v);
  endtask

  task automatic expect_now(input string tag, input logic [WIDTH-1:0] v);
    push_exp(tag, v);
    score();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic lvl);
    case (which)
      0: bus.up = lvl;
      1: bus.down = lvl;
      default: bus.ok = lvl;
    endcase
  endtask

  // which: 0=up 1=down 2=ok
  task automatic press(input int which);
    set_btn(which, 1'b0);
    cycles(3);
    set_btn(which, 1'b1);
    cycles(4);
  endtask

  task automatic enter_val(input int v);
    if (v == 15) begin
      press(1);
    end else begin
      for (int i = 0; i < v; i++) press(0);
    end
  endtask

  task automatic run_mult(input string tag, input int a, input int b);
    logic [2*WIDTH-1:0] p;
    p = 8'(a * b);
    enter_val(a);
    expect_now({tag, " A"}, 4'(a));
    press(2);
    expect_now({tag, " okA"}, 4'h0);
    enter_val(b);
    expect_now({tag, " B"}, 4'(b));
    push_exp({tag, " hi"}, p[2*WIDTH-1:WIDTH]);
    push_exp({tag, " lo"}, p[WIDTH-1:0]);
    push_exp({tag, " back"}, 4'h0);
    press(2);
    cycles(WIDTH + 1);
    score();
    press(2);
    score();
    press(2);
    score();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.up   = 1'b1;
    bus.down = 1'b1;
    bus.ok   = 1'b1;
    rst      = 1'b0;
    cycles(2);
    expect_now("reset", 4'h0);
    rst = 1'b1;
    cycles(2);

    run_mult("4x3", 4, 3);
    run_mult("15x15", 15, 15);

    // Held button: one pulse, with two-edge latency.
    bus.up = 1'b0;
    @(negedge clk);
    expect_now("lat k", 4'h0);
    @(negedge clk);
    expect_now("lat k+1", 4'h0);
    @(negedge clk);
    expect_now("lat k+2", 4'h1);
    cycles(17);
    bus.up = 1'b1;
    cycles(4);
    expect_now("held up", 4'h1);
    bus.up   = 1'b0;
    bus.down = 1'b0;
    cycles(3);
    bus.up   = 1'b1;
    bus.down = 1'b1;
    cycles(4);
    expect_now("up+down", 4'h1);
    press(2);
    expect_now("1x1 okA", 4'h0);
    press(0);
    expect_now("1x1 B", 4'h1);
    push_exp("1x1 hi", 4'h0);
    push_exp("1x1 lo", 4'h1);
    press(2);
    cycles(WIDTH + 1);
    score();
    press(2);
    score();
    press(2);
    expect_now("1x1 back", 4'h0);

    // 7x2 with up presses during CALC and SHOW_HI.
    enter_val(7);
    press(2);
    enter_val(2);
    expect_now("7x2 B", 4'h2);
    push_exp("7x2 calc", 4'h2);
    push_exp("7x2 hi", 4'h0);
    push_exp("7x2 hi up", 4'h0);
    push_exp("7x2 lo", 4'hE);
    push_exp("7x2 lo up", 4'hE);
    push_exp("7x2 back", 4'h0);
    bus.ok = 1'b0;
    @(negedge clk);
    bus.up = 1'b0;
    cycles(3);
    score();
    bus.ok = 1'b1;
    bus.up = 1'b1;
    cycles(6);
    score();
    press(0);
    score();
    press(2);
    score();
    press(0);
    score();
    press(2);
    score();

    // Reset one cycle into CALC, then A must be 0.
    enter_val(5);
    press(2);
    enter_val(3);
    expect_now("rst B", 4'h3);
    bus.ok = 1'b0;
    cycles(4);
    bus.ok = 1'b1;
    rst    = 1'b0;
    #1;
    expect_now("async rst", 4'h0);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    press(2);
    expect_now("0x9 okA", 4'h0);
    enter_val(9);
    expect_now("0x9 B", 4'h9);
    push_exp("0x9 hi", 4'h0);
    push_exp("0x9 lo", 4'h0);
    press(2);
    cycles(WIDTH + 1);
    score();
    press(2);
    score();
    press(2);
    expect_now("0x9 back", 4'h0);

    // ok held low through reset release must not advance the FSM.
    bus.ok = 1'b0;
    rst    = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(8);
    bus.ok = 1'b1;
    cycles(4);
    expect_now("ok held rst", 4'h0);
    enter_val(2);
    expect_now("held A", 4'h2);
    press(2);
    expect_now("held okA", 4'h0);
    enter_val(1);
    expect_now("held B", 4'h1);
    push_exp("2x1 hi", 4'h0);
    push_exp("2x1 lo", 4'h2);
    press(2);
    cycles(WIDTH + 1);
    score();
    press(2);
    score();
    press(2);
    expect_now("2x1 back", 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multiplicador_4b.md
Name: multiplicador_4b

Overview:
- Push-button multiplier for the same board UI as the 4-bit divider.
- User enters operand A, then operand B, with up/down buttons; ok confirms each entry.
- Block computes A*B with a sequential shift-add engine.
- 2*WIDTH-bit product is shown on the WIDTH LEDs, high nibble then low nibble, one ok press per nibble.

Parameters:
- WIDTH, 4, operand width; leds width; product is 2*WIDTH bits.
- SYNC_STAGES, 2, synchronizer flops per button input (min 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- down  input  1  button, active-low (pressed = 0), asynchronous to clk
- up  input  1  button, active-low (pressed = 0), asynchronous to clk
- ok  input  1  button, active-low (pressed = 0), asynchronous to clk
- leds  output  WIDTH  entry value or product nibble

Behaviour:
- Reset (rst=0, async):
  - state=LOAD_A; entry value=0; A=B=0; product=0; leds=0.
  - Synchronizer flops reset to 1 (released).
  - No press pulse may be generated on reset release, even if a button is held.
- Button conditioning:
  - Each button passes through SYNC_STAGES flops, then a falling-edge detector (prev=1, now=0).
  - Result is a one-cycle press pulse per press; a held button yields exactly one pulse.
  - Latency: with SYNC_STAGES=2, a press first sampled at clk edge k updates leds/state at edge k+2.
- Entry (LOAD_A, LOAD_B):
  - up pulse: value+1 mod 2^WIDTH (15 wraps to 0).
  - down pulse: value-1 mod 2^WIDTH (0 wraps to 15).
  - up and down pulses in the same cycle: value unchanged.
  - leds = current entry value.
- FSM:
  - LOAD_A: ok pulse -> A=value, value=0, go LOAD_B (ok wins over up/down in the same cycle).
  - LOAD_B: ok pulse -> B=value, clear accumulator, go CALC (ok wins over up/down in the same cycle).
  - CALC: one iteration per clk.
    - If the current multiplier LSB=1, add shifted A to the 2*WIDTH-bit accumulator.
    - Then shift.
    - After exactly WIDTH cycles, product=A*B and go SHOW_HI.
    - All buttons ignored; leds hold the last entry value (B).
  - SHOW_HI: leds=product[2W-1:W]; ok pulse -> SHOW_LO.
  - SHOW_LO: leds=product[W-1:0]; ok pulse -> LOAD_A with value=0, leds=0.
  - up/down ignored in CALC, SHOW_HI, SHOW_LO.
- Arithmetic: unsigned; product never overflows 2*WIDTH bits (max 15*15=225).
- Reset mid-operation (any state, including CALC): immediate return to reset values; partial product discarded.
- Outputs are registered; no combinational path from buttons to leds.

Decomposition:
- Shared package:
  - state encoding constants LOAD_A=0, LOAD_B=1, CALC=2, SHOW_HI=3, SHOW_LO=4 (3 bits).
  - BTN_PRESSED=1'b0.
  - Default WIDTH.
  - The divider reuses the state and button constants.
- One sub-module is natural: boton_pulso, the synchronizer plus falling-edge detector, instantiated three times. The divider shares this module.

Test Plan:
- Hold down=1, ok=1, rst pulsed low. Press up 4 times, ok. Press up 3 times, ok. Wait WIDTH+1 cycles -> leds=4'h0 (SHOW_HI). Press ok -> leds=4'hC (4*3=12).
- A=15 (one down press from 0, checks wrap to 15), B=15 (same) -> SHOW_HI leds=4'hE, ok -> leds=4'h1 (225=0xE1), ok -> LOAD_A, leds=0.
- Hold up low for 20 cycles -> value increments exactly once (leds=1). Drive up and down low on the same edge -> value unchanged.
- Enter A=7, B=2, press up during CALC and SHOW_HI -> ignored. Result 0x0/0xE.
- Assert rst low one cycle into CALC -> leds=0, state LOAD_A immediately. Press ok after release -> LOAD_B with A=0. Hold ok low through reset release -> no spurious transition.
- A=0, B=9 -> product 0x00 in both SHOW states. A=1, B=1 -> 0x0 then 0x1.
